// File: rtl/banked_frame_mem_if.sv
// banked_frame_mem_if: write/read/swap/clear bus between a frame producer-consumer and banked_frame_mem
// master: drives wr_*, rd_en/rd_addr, swap_req, clear_req; slave: drives rd_data/rd_valid/rd_err, swap_ack, busy, wr_bank/rd_bank
interface banked_frame_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BANKS  = 2
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_err;
  logic                    swap_req;
  logic                    swap_ack;
  logic                    clear_req;
  logic                    busy;
  logic [BANK_W-1:0]       wr_bank;
  logic [BANK_W-1:0]       rd_bank;
  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, swap_req, clear_req,
    input  rd_data, rd_valid, rd_err, swap_ack, busy, wr_bank, rd_bank
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, swap_req, clear_req,
    output rd_data, rd_valid, rd_err, swap_ack, busy, wr_bank, rd_bank
  );
endinterface

// File: rtl/banked_frame_mem.sv
// banked_frame_mem: multi-bank frame buffer, write bank / read bank swap, clear sweep, optional byte parity
// Ports: clk, reset (sync, active-high), fm (banked_frame_mem_if.slave).
// Define FRAME_MEM_PARITY_EN to store one even-parity bit per byte and flag rd_err on mismatch.
module banked_frame_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int NUM_BANKS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  banked_frame_mem_if.slave    fm
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int NB     = DATA_WIDTH / 8;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [BANK_W-1:0]     wr_bank_q, rd_bank;
  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_word;
  logic                  rd_valid_q, swap_ack_q, busy, wr_in, rd_in, wr_ok, rd_ok, swap_ok, last;
  assign busy    = state_q == CLEAR;
  assign rd_bank = wr_bank_q - BANK_W'(1);
  assign last    = clr_addr_q == ADDR_WIDTH'(MEM_DEPTH - 1);
  // Range checks only exist when the bank is shallower than the address space.
  if (MEM_DEPTH < (1 << ADDR_WIDTH)) begin : g_part
    assign wr_in = fm.wr_addr < ADDR_WIDTH'(MEM_DEPTH);
    assign rd_in = fm.rd_addr < ADDR_WIDTH'(MEM_DEPTH);
  end else begin : g_full
    assign wr_in = 1'b1;
    assign rd_in = 1'b1;
  end
  assign wr_ok   = fm.wr_en && !busy && wr_in && !reset;
  assign rd_ok   = fm.rd_en && !busy;
  assign swap_ok = fm.swap_req && !busy;
  assign rd_word = rd_in ? mem_q[rd_bank][fm.rd_addr] : '0;
  always_comb begin
    state_d    = busy ? (last ? IDLE : CLEAR) : (fm.clear_req ? CLEAR : IDLE);
    clr_addr_d = busy ? clr_addr_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      wr_bank_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      swap_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_valid_q <= rd_ok;
      swap_ack_q <= swap_ok;
      if (swap_ok) wr_bank_q <= wr_bank_q + 1'b1;
      if (rd_ok) rd_data_q <= rd_word;
    end
  end
  // Clear sweep and writes are mutually exclusive: writes are gated by busy.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++)
      if (busy) mem_q[b][clr_addr_q] <= '0;
    for (int k = 0; k < NB; k++)
      if (wr_ok && fm.wr_be[k]) mem_q[wr_bank_q][fm.wr_addr][8*k +: 8] <= fm.wr_data[8*k +: 8];
  end
`ifdef FRAME_MEM_PARITY_EN
  logic [NB-1:0] par_q [NUM_BANKS][MEM_DEPTH];
  logic [NB-1:0] wr_par, rd_par;
  logic          rd_err_q;
  for (genvar k = 0; k < NB; k++) begin : g_par
    assign wr_par[k] = ^fm.wr_data[8*k +: 8];
    assign rd_par[k] = ^rd_word[8*k +: 8];
  end
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++)
      if (busy) par_q[b][clr_addr_q] <= '0;
    for (int k = 0; k < NB; k++)
      if (wr_ok && fm.wr_be[k]) par_q[wr_bank_q][fm.wr_addr][k] <= wr_par[k];
  end
  always_ff @(posedge clk) begin
    if (reset) rd_err_q <= 1'b0;
    else rd_err_q <= rd_ok && rd_in && (rd_par != par_q[rd_bank][fm.rd_addr]);
  end
  assign fm.rd_err = rd_err_q;
`else
  assign fm.rd_err = 1'b0;
`endif
  assign fm.rd_data  = rd_data_q;
  assign fm.rd_valid = rd_valid_q;
  assign fm.swap_ack = swap_ack_q;
  assign fm.busy     = busy;
  assign fm.wr_bank  = wr_bank_q;
  assign fm.rd_bank  = rd_bank;
endmodule

// File: tb/tb_banked_frame_mem.sv
// tb_banked_frame_mem: directed, scoreboard-checked bench for banked_frame_mem
module tb_banked_frame_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  banked_frame_mem_if fm();
  banked_frame_mem dut (.clk(clk), .reset(reset), .fm(fm));
  int total = 0;
  int bad = 0;
  int wb = 0;
  logic [31:0] sbq [$];
  logic [31:0] mdl [2][16];
  logic [31:0] last_rd;
  logic exp_err = 1'b0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rd_valid", fm.rd_valid, sbq.size() != 0);
    if (fm.rd_valid === 1'b1 && sbq.size() != 0) begin
      chk("rd_data", fm.rd_data, sbq.pop_front());
      chk("rd_err", fm.rd_err, exp_err);
    end
  endtask
  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    fm.wr_en = 1'b1;
    fm.wr_addr = a[3:0];
    fm.wr_data = d;
    fm.wr_be = be;
    for (int k = 0; k < 4; k++) if (be[k]) mdl[wb][a][8*k +: 8] = d[8*k +: 8];
    tick();
    fm.wr_en = 1'b0;
  endtask
  task automatic rd(input int a);
    fm.rd_en = 1'b1;
    fm.rd_addr = a[3:0];
    last_rd = mdl[(wb + 1) % 2][a];
    sbq.push_back(last_rd);
    tick();
    fm.rd_en = 1'b0;
  endtask
  task automatic bank_chk();
    chk("wr_bank", fm.wr_bank, wb);
    chk("rd_bank", fm.rd_bank, (wb + 1) % 2);
  endtask
  task automatic swap_done();
    wb = (wb + 1) % 2;
    chk("swap_ack", fm.swap_ack, 1);
    bank_chk();
    tick();
    chk("swap_ack_pulse", fm.swap_ack, 0);
  endtask
  task automatic swap();
    fm.swap_req = 1'b1;
    tick();
    fm.swap_req = 1'b0;
    swap_done();
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk(tag, fm.busy, 1);
      chk("no_swap_ack", fm.swap_ack, 0);
      tick();
    end
    chk("busy_end", fm.busy, 0);
    for (int b = 0; b < 2; b++) for (int a = 0; a < 16; a++) mdl[b][a] = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fm.swap_req = 1'b0;
    fm.wr_en = 1'b0;
    wb = 0;
    bank_chk();
    chk("rst_rd_data", fm.rd_data, 0);
    chk("rst_swap_ack", fm.swap_ack, 0);
    chk("rst_rd_err", fm.rd_err, 0);
    sweep("rst_busy");
  endtask
  initial begin
    fm.wr_en = 1'b0;
    fm.wr_addr = '0;
    fm.wr_data = '0;
    fm.wr_be = '0;
    fm.rd_en = 1'b0;
    fm.rd_addr = '0;
    fm.swap_req = 1'b0;
    fm.clear_req = 1'b0;
    do_reset();
    wr(3, 32'hDEADBEEF, 4'b1111);
    wr(3, 32'h000000AA, 4'b0001);
    swap();
    rd(3);
    tick();
    chk("rd_hold", fm.rd_data, last_rd);
    swap();
    fm.swap_req = 1'b1;
    wr(5, 32'h11111111, 4'b1111);
    fm.swap_req = 1'b0;
    swap_done();
    rd(5);
    rd(3);
    swap();
    rd(5);
    wr(9, 32'h12345678, 4'b1010);
    wr(10, 32'hA5A5A5A5, 4'b0100);
    swap();
    rd(9);
    rd(10);
    rd(3);
    fm.clear_req = 1'b1;
    tick();
    fm.clear_req = 1'b0;
    fm.wr_en = 1'b1;
    fm.wr_addr = 4'd3;
    fm.wr_data = 32'hFFFFFFFF;
    fm.wr_be = 4'b1111;
    fm.rd_en = 1'b1;
    fm.rd_addr = 4'd3;
    fm.swap_req = 1'b1;
    fm.clear_req = 1'b1;
    sweep("clr_busy");
    fm.wr_en = 1'b0;
    fm.rd_en = 1'b0;
    fm.swap_req = 1'b0;
    fm.clear_req = 1'b0;
    bank_chk();
    for (int a = 0; a < 16; a++) rd(a);
    swap();
    for (int a = 0; a < 16; a++) rd(a);
    fm.clear_req = 1'b1;
    tick();
    fm.clear_req = 1'b0;
    repeat (5) tick();
    fm.swap_req = 1'b1;
    fm.wr_en = 1'b1;
    do_reset();
`ifdef FRAME_MEM_PARITY_EN
    wr(7, 32'hCAFEF00D, 4'b1111);
    wr(8, 32'h0F0F0F01, 4'b1111);
    swap();
    dut.mem_q[0][7][0] = ~dut.mem_q[0][7][0];
    mdl[0][7][0] = ~mdl[0][7][0];
    exp_err = 1'b1;
    rd(7);
    exp_err = 1'b0;
    rd(8);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
